// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the writeback port arbiter and other
// shared-resource arbiters built on rr_grant.
package wb_arb_pkg;

  localparam int WB_ARB_MAX_REQ = 8;
  localparam int WB_ARB_IDX_W   = 3;
  localparam int WB_ARB_TID_W   = 3;
  localparam int WB_ARB_XLEN    = 64;

  typedef struct packed {
    logic [WB_ARB_TID_W-1:0] trans_id;
    logic [WB_ARB_XLEN-1:0]  data;
    logic                    ex_valid;
    logic [WB_ARB_XLEN-1:0]  ex_cause;
    logic [WB_ARB_XLEN-1:0]  ex_tval;
  } wb_req_t;

  // Returns {found, index} of the first set bit at or above ptr, wrapping mod n.
  function automatic logic [WB_ARB_IDX_W:0] rr_first(
    input logic [WB_ARB_MAX_REQ-1:0] valid,
    input logic [WB_ARB_IDX_W-1:0]   ptr,
    input int                        n
  );
    logic [WB_ARB_IDX_W:0] res;
    int idx;
    res = '0;
    // Walk downward so the closest hit to ptr is the one that sticks.
    for (int k = WB_ARB_MAX_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % n;
      if (k < n && valid[idx[WB_ARB_IDX_W-1:0]])
        res = {1'b1, idx[WB_ARB_IDX_W-1:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Requester-side result buses and scoreboard writeback signals of the arbiter.
interface wb_port_arbiter_if #(
  parameter int unsigned NrReq       = 4,
  parameter int unsigned TransIdBits = 3,
  parameter int unsigned XLEN        = 64
);
  logic [NrReq-1:0]                  req_valid_i;
  logic [NrReq-1:0]                  req_ready_o;
  logic [NrReq-1:0][TransIdBits-1:0] req_trans_id_i;
  logic [NrReq-1:0][XLEN-1:0]        req_data_i;
  logic [NrReq-1:0]                  req_ex_valid_i;
  logic [NrReq-1:0][XLEN-1:0]        req_ex_cause_i;
  logic [NrReq-1:0][XLEN-1:0]        req_ex_tval_i;
  logic                              wt_valid_o;
  logic [TransIdBits-1:0]            trans_id_o;
  logic [XLEN-1:0]                   wbdata_o;
  logic                              ex_valid_o;
  logic [XLEN-1:0]                   ex_cause_o;
  logic [XLEN-1:0]                   ex_tval_o;

  modport slave (
    input  req_valid_i, req_trans_id_i, req_data_i, req_ex_valid_i,
           req_ex_cause_i, req_ex_tval_i,
    output req_ready_o, wt_valid_o, trans_id_o, wbdata_o, ex_valid_o,
           ex_cause_o, ex_tval_o
  );

  modport master (
    output req_valid_i, req_trans_id_i, req_data_i, req_ex_valid_i,
           req_ex_cause_i, req_ex_tval_i,
    input  req_ready_o, wt_valid_o, trans_id_o, wbdata_o, ex_valid_o,
           ex_cause_o, ex_tval_o
  );
endinterface

// File: rtl/rr_grant.sv
// Round-robin pointer plus one-hot combinational grant; optional fixed
// priority for index 0 with round-robin among the rest.
module rr_grant
  import wb_arb_pkg::*;
#(
  parameter  int unsigned N          = 4,
  parameter  bit          FixedPrio0 = 1'b0,
  localparam int unsigned IdxW       = $clog2(N)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic [N-1:0]    valid_i,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] gnt_idx_o,
  output logic            gnt_valid_o
);

  logic [IdxW-1:0]           ptr_q, ptr_d;
  logic [WB_ARB_MAX_REQ-1:0] rr_vld;
  logic [WB_ARB_IDX_W:0]     hit;

  always_comb begin
    rr_vld         = '0;
    rr_vld[N-1:0]  = valid_i;
    if (FixedPrio0) rr_vld[0] = 1'b0;
    hit         = rr_first(rr_vld, WB_ARB_IDX_W'(ptr_q), int'(N));
    gnt_valid_o = 1'b0;
    gnt_idx_o   = '0;
    if (!flush_i) begin
      if (FixedPrio0 && valid_i[0]) begin
        gnt_valid_o = 1'b1;
      end else if (hit[WB_ARB_IDX_W]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = IdxW'(hit[WB_ARB_IDX_W-1:0]);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < int'(N); i++)
      gnt_o[i] = gnt_valid_o && (gnt_idx_o == IdxW'(i));
  end

  // Fixed-priority grants to index 0 leave the round-robin order untouched.
  always_comb begin
    ptr_d = ptr_q;
    if (gnt_valid_o && !(FixedPrio0 && gnt_idx_o == '0))
      ptr_d = IdxW'((int'(gnt_idx_o) + 1) % int'(N));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares one scoreboard writeback port among NrReq result sources.
// Build with CVA6_WB_ARB_FIXED_PRIO_EN to give requester 0 fixed priority.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned NrReq       = 4,
  parameter int unsigned TransIdBits = WB_ARB_TID_W,
  parameter int unsigned XLEN        = WB_ARB_XLEN
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  wb_port_arbiter_if.slave   bus,
  output logic               conflict_o
);

  localparam int unsigned IdxW = $clog2(NrReq);
`ifdef CVA6_WB_ARB_FIXED_PRIO_EN
  localparam bit FixedPrio = 1'b1;
`else
  localparam bit FixedPrio = 1'b0;
`endif

  // The payload struct lives in the package, so its widths bound the parameters.
  if (TransIdBits != WB_ARB_TID_W || XLEN != WB_ARB_XLEN || NrReq > WB_ARB_MAX_REQ
      || NrReq < 2) begin : g_param_chk
    $error("wb_port_arbiter: parameters outside wb_arb_pkg payload sizing");
  end

  logic [NrReq-1:0] gnt;
  logic [IdxW-1:0]  gnt_idx;
  logic             gnt_vld;
  wb_req_t          sel, wb_q;
  logic             wt_valid_q;

  rr_grant #(.N(NrReq), .FixedPrio0(FixedPrio)) u_grant (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .valid_i     (bus.req_valid_i),
    .gnt_o       (gnt),
    .gnt_idx_o   (gnt_idx),
    .gnt_valid_o (gnt_vld)
  );

  assign bus.req_ready_o = gnt;

  always_comb begin
    sel.trans_id = bus.req_trans_id_i[gnt_idx];
    sel.data     = bus.req_data_i[gnt_idx];
    sel.ex_valid = bus.req_ex_valid_i[gnt_idx];
    sel.ex_cause = bus.req_ex_cause_i[gnt_idx];
    sel.ex_tval  = bus.req_ex_tval_i[gnt_idx];
  end

  // Payload only loads on a transfer so idle cycles keep the last result visible.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wt_valid_q <= 1'b0;
      wb_q       <= '0;
      conflict_o <= 1'b0;
    end else begin
      wt_valid_q <= gnt_vld;
      if (gnt_vld) wb_q <= sel;
      conflict_o <= !flush_i && ($countones(bus.req_valid_i) > 1);
    end
  end

  assign bus.wt_valid_o = wt_valid_q;
  assign bus.trans_id_o = wb_q.trans_id;
  assign bus.wbdata_o   = wb_q.data;
  assign bus.ex_valid_o = wt_valid_q & wb_q.ex_valid;
  assign bus.ex_cause_o = wb_q.ex_cause;
  assign bus.ex_tval_o  = wb_q.ex_tval;

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares a single scoreboard writeback port among NrReq functional-unit result sources (e.g. LSU, mult, CVXIF, FPU).
- Sits between the execute-stage result buses and the scoreboard writeback inputs (trans_id / wbdata / ex / wt_valid).
- Round-robin grant with a registered output stage; one result written back per cycle.
- Ungranted requesters are back-pressured through a valid/ready handshake.

Parameters:
- NrReq, 4, number of requesting functional units (2..8)
- TransIdBits, 3, width of scoreboard transaction ID
- XLEN, 64, result data and exception cause/tval width

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous reset, active low
- flush_i  in  1  pipeline flush from controller
- req_valid_i  in  NrReq  requester i holds a result
- req_ready_o  out  NrReq  requester i granted this cycle
- req_trans_id_i  in  NrReq x TransIdBits  per-requester transaction ID
- req_data_i  in  NrReq x XLEN  per-requester result data
- req_ex_valid_i  in  NrReq  per-requester exception flag
- req_ex_cause_i  in  NrReq x XLEN  per-requester exception cause
- req_ex_tval_i  in  NrReq x XLEN  per-requester exception tval
- wt_valid_o  out  1  writeback valid to scoreboard
- trans_id_o  out  TransIdBits  writeback transaction ID
- wbdata_o  out  XLEN  writeback data
- ex_valid_o  out  1  writeback exception flag
- ex_cause_o  out  XLEN  writeback exception cause
- ex_tval_o  out  XLEN  writeback exception tval
- conflict_o  out  1  perf pulse: more than one requester valid this cycle

Behaviour:
- Clock/reset: one clock, clk_i; reset rst_ni is asynchronous, active low.
- Reset values: all outputs 0; round-robin pointer = 0.
- Handshake:
  - A transfer occurs when req_valid_i[i] && req_ready_o[i].
  - A requester holds valid and payload stable until ready.
  - req_ready_o is combinational from req_valid_i, the pointer and flush_i, and is one-hot or zero.
- Grant:
  - Grant the first valid requester at or above the pointer, wrapping modulo NrReq.
  - After a grant to index g, the pointer becomes (g+1) mod NrReq.
  - With no valid requester, the pointer holds.
- Latency: the payload of a granted requester appears on trans_id_o/wbdata_o/ex_* with wt_valid_o=1 exactly one cycle after the transfer.
- Throughput: one result per cycle. The scoreboard never back-pressures; there is no output ready.
- Idle: with no transfer in cycle N, wt_valid_o=0 in N+1. Data outputs hold their last value; ex_valid_o=0 whenever wt_valid_o=0.
- Single requester: granted every cycle it is valid, giving full throughput.
- Flush:
  - While flush_i=1, req_ready_o=0 and no transfer occurs.
  - wt_valid_o is forced 0 in the cycle after flush_i; an output registered in the flush cycle is dropped.
  - The pointer is not reset by flush.
- conflict_o: registered; 1 in cycle N+1 when popcount(req_valid_i)>1 in cycle N and flush_i=0.
- Reset mid-operation: the asynchronous clear overrides everything. Requesters must re-present results after reset.

Optional Feature:
- Macro: CVA6_WB_ARB_FIXED_PRIO_EN.
- Defined: requester 0 (the lowest-latency unit) always wins when valid. Remaining requesters use round-robin among indices 1..NrReq-1, and the pointer advances only on grants to indices ≥1.
- Undefined: pure round-robin across all NrReq requesters, as specified above.

Decomposition:
- Package wb_arb_pkg holds:
  - typedef wb_req_t: trans_id, data, ex_valid, ex_cause, ex_tval.
  - Constant WB_ARB_MAX_REQ = 8.
  - Function for a rotate-and-find-first index.
- Sub-module rr_grant: pointer register plus combinational one-hot grant. It takes valid vector and flush and returns the grant vector and index. It is reused by other shared-resource arbiters.
- Top level instantiates rr_grant, the payload mux, the output register and the conflict register.

Test Plan:
- Reset: assert rst_ni=0 mid-stream with requesters 1,2 valid → all outputs 0 immediately; after release, first grant goes to index 1 (pointer 0, index 0 idle).
- Rotation: all 4 valid continuously with trans_ids 0..3 → wt_valid_o=1 every cycle; trans_id_o sequence 0,1,2,3,0; conflict_o=1 every cycle after the first.
- Wrap: pointer=3, valid={0,1} only → grant index 0, then 1; pointer ends at 2.
- Flush: req 2 granted in cycle N with flush_i=1 in N+1 → req_ready_o=0 in N+1; wt_valid_o=0 in N+2; req 2 retains valid and is re-granted after flush deasserts.
- Exception path: req 1 with ex_valid=1, cause=0x5, tval=0x8000_1000, trans_id=6 → next cycle ex_valid_o=1, ex_cause_o=0x5, ex_tval_o=0x8000_1000, trans_id_o=6.
- CVA6_WB_ARB_FIXED_PRIO_EN: req 0 valid continuously plus req 3 valid → only req 0 granted while valid. Undefined build → grants alternate 0,3,0,3.
